// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Optional watchdog abort is built in when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       done_o,
  output logic       err_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);
  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_TX, S_ACK, S_WAIT_IDLE} state_e;

  state_e state_q, state_d;

  logic             clk_s1, clk_s2, data_s1, data_s2;
  logic             clk_prev, clk_curr, fall;
  logic [7:0]       shift_q;
  logic             parity_q, drive_q, ack_bad_q;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic             inh_last;
  logic             done_q, err_q, done_d, err_d;
  logic             wd_expired;

  // Lines idle high, so the synchronisers and edge pair reset to 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      clk_curr <= 1'b1;
      clk_prev <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_i;
      clk_s2   <= clk_s1;
      data_s1  <= ps2_data_i;
      data_s2  <= data_s1;
      clk_curr <= clk_s2;
      clk_prev <= clk_curr;
    end
  end

  assign fall     = clk_prev & ~clk_curr;
  assign inh_last = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;

  assign wd_active = (state_q == S_TX) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        wd_cnt <= '0;
    else if (wd_active) wd_cnt <= wd_cnt + WD_W'(1);
    else                wd_cnt <= '0;
  end

  assign wd_expired = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: a silent device parks the block until reset.
  assign wd_expired = (TIMEOUT_CYCLES == 32'd0) & 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE:      if (valid_i) state_d = S_INHIBIT;
      S_INHIBIT:   if (inh_last) state_d = S_TX;
      S_TX:        if (fall && bit_cnt == 4'd9) state_d = S_ACK;
      S_ACK:       if (fall) state_d = S_WAIT_IDLE;
      S_WAIT_IDLE: begin
        if (clk_s2 && data_s2) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = ack_bad_q;
        end
      end
      default:     state_d = S_IDLE;
    endcase
    if (wd_expired) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      err_d   = 1'b1;
    end
  end

  // Bit counter 0 in S_TX is the request-to-send phase (start bit held low).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q   <= '0;
      parity_q  <= 1'b0;
      drive_q   <= 1'b0;
      ack_bad_q <= 1'b0;
      bit_cnt   <= '0;
      inh_cnt   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            shift_q   <= data_i;
            parity_q  <= ~^data_i;
            inh_cnt   <= '0;
            ack_bad_q <= 1'b0;
          end
        end
        S_INHIBIT: begin
          inh_cnt <= inh_cnt + INH_W'(1);
          if (inh_last) begin
            drive_q <= 1'b1;
            bit_cnt <= '0;
          end
        end
        S_TX: begin
          if (fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              drive_q <= ~shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end else if (bit_cnt == 4'd8) begin
              drive_q <= ~parity_q;
            end else begin
              drive_q <= 1'b0;
            end
          end
        end
        S_ACK:   if (fall) ack_bad_q <= data_s2;
        default: ;
      endcase
    end
  end

  assign ready_o       = (state_q == S_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign ps2_clk_oe_o  = (state_q == S_INHIBIT);
  assign ps2_data_oe_o = ((state_q == S_INHIBIT) && inh_last) || ((state_q == S_TX) && drive_q);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
// Timeout scenario is exercised when PS2_TX_TIMEOUT_EN is defined.
module tb_ps2_host_tx;
  localparam int unsigned INH = 50;
  localparam int unsigned TO  = 300;
  localparam int          H   = 40;

  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b0;
  logic [7:0] data_i  = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o, done_o, err_o, clk_oe, data_oe;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk, ps2_data;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic last_err = 1'b0;

  assign ps2_clk  = dev_clk & ~clk_oe;
  assign ps2_data = dev_data & ~data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .ps2_clk_i     (ps2_clk),
    .ps2_data_i    (ps2_data),
    .ps2_clk_oe_o  (clk_oe),
    .ps2_data_oe_o (data_oe)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (done_o) begin
      done_cnt++;
      last_err = err_o;
    end
    if (err_o) err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame bits as the device sees them after the start bit: data LSB first, odd parity, stop.
  function automatic logic [9:0] frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  task automatic host_send(input logic [7:0] b);
    data_i  = b;
    valid_i = 1'b1;
    check("ready_before_accept", ready_o, 1'b1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    data_i  = 8'($urandom);
    check("clk_oe_after_accept", clk_oe, 1'b1);
    check("ready_busy", ready_o, 1'b0);
    check("data_oe_early_inhibit", data_oe, 1'b0);
    repeat (INH - 1) @(posedge clk_i);
    #1;
    check("clk_oe_last_inhibit", clk_oe, 1'b1);
    check("start_bit_early", data_oe, 1'b1);
    @(posedge clk_i); #1;
    check("rts_clk_released", clk_oe, 1'b0);
    check("rts_data_low", data_oe, 1'b1);
  endtask

  task automatic device_xfer(input bit ack, input int edges, output logic [9:0] bits);
    int t;
    bits = '0;
    t = 0;
    while (ps2_clk !== 1'b0 && t < 200) begin @(posedge clk_i); #1; t++; end
    check("dev_saw_inhibit", ps2_clk, 1'b0);
    t = 0;
    while (ps2_clk !== 1'b1 && t < int'(INH) + 50) begin @(posedge clk_i); #1; t++; end
    check("dev_saw_rts", ps2_clk, 1'b1);
    check("dev_start_bit", ps2_data, 1'b0);
    for (int k = 1; k <= edges && k <= 10; k++) begin
      repeat (H) @(posedge clk_i);
      #1;
      dev_clk = 1'b0;
      repeat (H) @(posedge clk_i);
      #1;
      dev_clk = 1'b1;
      bits[k-1] = ps2_data;
    end
    if (edges >= 11) begin
      repeat (H / 2) @(posedge clk_i);
      #1;
      if (ack) dev_data = 1'b0;
      repeat (H / 2) @(posedge clk_i);
      #1;
      dev_clk = 1'b0;
      repeat (H) @(posedge clk_i);
      #1;
      dev_clk = 1'b1;
      repeat (4) @(posedge clk_i);
      #1;
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input int prev_cnt, input string tag);
    int t;
    t = 0;
    while (done_cnt == prev_cnt && t < 200) begin @(posedge clk_i); #1; t++; end
    check(tag, done_cnt, prev_cnt + 1);
  endtask

  task automatic full_xfer(input logic [7:0] b, input bit ack, input string tag);
    logic [9:0] bits;
    int pd, pe;
    pd = done_cnt;
    pe = err_cnt;
    fork
      host_send(b);
      device_xfer(ack, 11, bits);
    join
    check({tag, "_frame"}, bits, frame(b));
    wait_done(pd, {tag, "_done"});
    check({tag, "_err_flag"}, last_err, !ack);
    check({tag, "_err_count"}, err_cnt, pe + (ack ? 0 : 1));
    check({tag, "_clk_oe_after"}, clk_oe, 1'b0);
    check({tag, "_data_oe_after"}, data_oe, 1'b0);
  endtask

  initial begin
    logic [9:0] bits;
    logic [7:0] rb;
    bit         rack;
    int         pd;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", ready_o, 1'b1);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_clk_oe", clk_oe, 1'b0);
    check("rst_data_oe", data_oe, 1'b0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("post_rst_ready", ready_o, 1'b1);

    // 0xED with ack, plus explicit bit pattern from the command definition
    pd = done_cnt;
    fork
      host_send(8'hED);
      device_xfer(1'b1, 11, bits);
    join
    check("ed_bits", bits, 10'b11_1110_1101);
    wait_done(pd, "ed_done");
    check("ed_err", last_err, 1'b0);
    @(posedge clk_i); #1;
    check("done_single_pulse", done_cnt, pd + 1);

    full_xfer(8'h01, 1'b1, "b2b_01");
    full_xfer(8'hFF, 1'b1, "b2b_ff");

    for (int i = 0; i < 3; i++) begin
      rb   = 8'($urandom);
      rack = 1'($urandom);
      full_xfer(rb, rack, "rand");
    end

    full_xfer(8'h3C, 1'b0, "nack");

    // 0x55 request raised mid-transfer must not disturb the 0xF4 frame
    pd = done_cnt;
    fork
      host_send(8'hF4);
      device_xfer(1'b1, 11, bits);
      begin
        repeat (150) @(posedge clk_i);
        #1;
        data_i  = 8'h55;
        valid_i = 1'b1;
        repeat (150) @(posedge clk_i);
        #1;
        check("ignored_valid_ready", ready_o, 1'b0);
        repeat (250) @(posedge clk_i);
        #1;
        valid_i = 1'b0;
      end
    join
    check("ignore_frame", bits, frame(8'hF4));
    wait_done(pd, "ignore_done");
    repeat (3) @(posedge clk_i);
    #1;
    check("ignore_no_restart", clk_oe, 1'b0);
    check("ignore_ready", ready_o, 1'b1);

    // Reset after edge 4 of 0xF0 (bit 3 is 0, so data is being pulled low)
    pd = done_cnt;
    fork
      host_send(8'hF0);
      device_xfer(1'b1, 4, bits);
    join
    repeat (5) @(posedge clk_i);
    #1;
    check("pre_reset_data_oe", data_oe, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("reset_clk_oe", clk_oe, 1'b0);
    check("reset_data_oe", data_oe, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_no_done", done_cnt, pd);
    check("reset_ready", ready_o, 1'b1);

`ifdef PS2_TX_TIMEOUT_EN
    pd = done_cnt;
    host_send(8'hA5);
    repeat (TO - 1) @(posedge clk_i);
    #1;
    check("timeout_not_early", done_o, 1'b0);
    @(posedge clk_i); #1;
    check("timeout_done", done_o, 1'b1);
    check("timeout_err", err_o, 1'b1);
    check("timeout_ready", ready_o, 1'b1);
    check("timeout_data_oe", data_oe, 1'b0);
    @(posedge clk_i); #1;
    check("timeout_done_count", done_cnt, pd + 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
